// File: rtl/cpu_step_controller.sv
// Execution sequencer: issues one-cycle cpu_ce pulses in halted / free-run / single-step / breakpoint modes.
// Optional build macro RUN_LIMIT_EN adds a run_limit input that stops RUN after a fixed number of pulses.
module cpu_step_controller #(
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PC_W            = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run_sw,
    input  logic            step_key,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
`ifdef RUN_LIMIT_EN
    input  logic [15:0]     run_limit,
`endif
    output logic            cpu_ce,
    output logic [1:0]      state,
    output logic            halted,
    output logic [15:0]     step_count
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    logic              run_meta_r;
    logic              run_sync_r;
    logic              key_meta_r;
    logic              key_sync_r;
    logic              key_acc_r;
    logic [DB_W-1:0]   db_cnt_r;
    state_t            state_r;
    state_t            next_state_s;
    logic              cpu_ce_r;
    logic              halted_r;
    logic [15:0]       step_count_r;
    logic [TICK_W-1:0] tick_r;
    logic              bp_skip_r;

    logic              key_diff_s;
    logic              db_done_s;
    logic              step_evt_s;
    logic              tick_due_s;
    logic              bp_match_s;
    logic              run_req_s;
    logic              limit_hit_s;
    logic              ce_next_s;
    logic              bp_hit_s;

`ifdef RUN_LIMIT_EN
    logic [15:0]       run_cnt_r;
    logic              run_block_r;
`endif

    // Two-flop synchronizers; the key idles high (released)
    always_ff @(posedge clk) begin
        if (rst) begin
            run_meta_r <= 1'b0;
            run_sync_r <= 1'b0;
            key_meta_r <= 1'b1;
            key_sync_r <= 1'b1;
        end else begin
            run_meta_r <= run_sw;
            run_sync_r <= run_meta_r;
            key_meta_r <= step_key;
            key_sync_r <= key_meta_r;
        end
    end

    // Debounce qualification; a press is a 1->0 change of the accepted level
    always_comb begin
        key_diff_s = (key_sync_r != key_acc_r);
        db_done_s  = key_diff_s && (db_cnt_r == DB_LAST);
        step_evt_s = db_done_s && key_acc_r;
    end

    // Accepted key level and stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            key_acc_r <= 1'b1;
            db_cnt_r  <= '0;
        end else if (db_done_s) begin
            key_acc_r <= key_sync_r;
            db_cnt_r  <= '0;
        end else if (key_diff_s) begin
            key_acc_r <= key_acc_r;
            db_cnt_r  <= db_cnt_r + DB_W'(1);
        end else begin
            key_acc_r <= key_acc_r;
            db_cnt_r  <= '0;
        end
    end

    // Run request qualification; a spent run limit blocks RUN until run_sw drops
    always_comb begin
        tick_due_s = (tick_r == TICK_LAST);
        bp_match_s = bp_en && (pc == bp_addr) && !bp_skip_r;
`ifdef RUN_LIMIT_EN
        run_req_s   = run_sync_r && !run_block_r;
        limit_hit_s = (state_r == ST_RUN) && tick_due_s && !bp_match_s &&
                      (run_limit != 16'd0) && ((run_cnt_r + 16'd1) == run_limit);
`else
        run_req_s   = run_sync_r;
        limit_hit_s = 1'b0;
`endif
    end

    // Next-state and pulse decision
    always_comb begin
        next_state_s = state_r;
        ce_next_s    = 1'b0;
        bp_hit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A pulse still in flight from RUN blocks a step so cpu_ce never doubles
                if (run_req_s) begin
                    next_state_s = ST_RUN;
                end else if (step_evt_s && !cpu_ce_r) begin
                    next_state_s = ST_STEP;
                    ce_next_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (run_req_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (tick_due_s && bp_match_s) begin
                    next_state_s = ST_BREAK;
                    bp_hit_s     = 1'b1;
                end else begin
                    ce_next_s = tick_due_s;
                    if (!run_sync_r || limit_hit_s) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
            end
            ST_BREAK: begin
                if (step_evt_s) begin
                    next_state_s = ST_STEP;
                    ce_next_s    = 1'b1;
                end else if (!run_sync_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_BREAK;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, pulse and halted registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cpu_ce_r <= 1'b0;
            halted_r <= 1'b1;
        end else begin
            state_r  <= next_state_s;
            cpu_ce_r <= ce_next_s;
            halted_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_BREAK);
        end
    end

    // Rate divider; held at zero outside RUN so every entry starts a full period
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= '0;
        end else if (state_r == ST_RUN) begin
            tick_r <= tick_due_s ? '0 : (tick_r + TICK_W'(1));
        end else begin
            tick_r <= '0;
        end
    end

    // Pulse counter and breakpoint skip flag
    always_ff @(posedge clk) begin
        if (rst) begin
            step_count_r <= 16'd0;
            bp_skip_r    <= 1'b0;
        end else if (ce_next_s) begin
            step_count_r <= step_count_r + 16'd1;
            bp_skip_r    <= 1'b0;
        end else if (bp_hit_s) begin
            step_count_r <= step_count_r;
            bp_skip_r    <= 1'b1;
        end else begin
            step_count_r <= step_count_r;
            bp_skip_r    <= bp_skip_r;
        end
    end

`ifdef RUN_LIMIT_EN
    // Pulses issued since RUN entry, and the block that holds IDLE after the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_r   <= 16'd0;
            run_block_r <= 1'b0;
        end else begin
            if (state_r != ST_RUN) begin
                run_cnt_r <= 16'd0;
            end else if (ce_next_s) begin
                run_cnt_r <= run_cnt_r + 16'd1;
            end else begin
                run_cnt_r <= run_cnt_r;
            end
            if (limit_hit_s) begin
                run_block_r <= 1'b1;
            end else if (!run_sync_r) begin
                run_block_r <= 1'b0;
            end else begin
                run_block_r <= run_block_r;
            end
        end
    end
`endif

    assign cpu_ce     = cpu_ce_r;
    assign state      = state_r;
    assign halted     = halted_r;
    assign step_count = step_count_r;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed scenarios plus random stimulus against a behavioural model.
// Define RUN_LIMIT_EN for both files to exercise the run-limit feature.
module tb_cpu_step_controller;

    localparam int TD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw;
    logic        step_key;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] step_count;
`ifdef RUN_LIMIT_EN
    logic [15:0] run_limit;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: mode uses the published numbering 0=IDLE 1=RUN 2=STEP 3=BREAK
    int m_mode, m_count, m_runcyc, m_mism, m_pulses;
    bit m_ce, m_skip, m_acc, m_block;
    bit key_q[$];
    bit run_q[$];

    cpu_step_controller #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_key(step_key),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
`ifdef RUN_LIMIT_EN
        .run_limit(run_limit),
`endif
        .cpu_ce(cpu_ce), .state(state), .halted(halted), .step_count(step_count)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit ks, rs, evt, prev_ce, nce, go_run, hit, due;
        int nmode;
        if (rst) begin
            m_mode = 0; m_ce = 0; m_count = 0; m_skip = 0; m_runcyc = 0;
            m_acc = 1; m_mism = 0; m_block = 0; m_pulses = 0;
            key_q = {1'b1, 1'b1};
            run_q = {1'b0, 1'b0};
            return;
        end
        key_q.push_front(step_key);
        ks = key_q.pop_back();
        run_q.push_front(run_sw);
        rs = run_q.pop_back();
        evt = 0;
        if (ks != m_acc) begin
            m_mism++;
            if (m_mism == DB) begin
                m_acc = ks; m_mism = 0; evt = (ks == 1'b0);
            end
        end else begin
            m_mism = 0;
        end
        prev_ce = m_ce; nce = 0; nmode = m_mode; hit = 0;
        go_run = rs && !m_block;
        case (m_mode)
            0: if (go_run) nmode = 1;
               else if (evt && !prev_ce) begin nmode = 2; nce = 1; end
            2: nmode = go_run ? 1 : 0;
            1: begin
                due = ((m_runcyc % TD) == TD - 1);
                if (due && bp_en && pc == bp_addr && !m_skip) begin
                    nmode = 3; m_skip = 1;
                end else begin
                    if (due) begin
                        nce = 1; m_pulses++;
`ifdef RUN_LIMIT_EN
                        if (run_limit != 0 && m_pulses == run_limit) hit = 1;
`endif
                    end
                    if (!rs || hit) nmode = 0;
                end
            end
            default: if (evt) begin nmode = 2; nce = 1; end
                     else if (!rs) nmode = 0;
        endcase
        if (hit) m_block = 1;
        else if (!rs) m_block = 0;
        if (nce) begin m_count = (m_count + 1) % 65536; m_skip = 0; end
        if (nmode == 1 && m_mode != 1) begin m_runcyc = 0; m_pulses = 0; end
        else if (nmode == 1) m_runcyc++;
        m_mode = nmode; m_ce = nce;
    endtask

    // One clock: model, edge, compare, then the processor PC follows the pulse
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("cpu_ce", cpu_ce, m_ce);
        chk("state", state, m_mode);
        chk("halted", halted, (m_mode == 0 || m_mode == 3));
        chk("step_count", step_count, m_count);
        if (rst) pc = 8'd0;
        else if (m_ce) pc = pc + 8'd1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        bit ok;
        int c0;
        rst = 1'b1; run_sw = 1'b0; step_key = 1'b1; bp_en = 1'b0; bp_addr = 8'd0; pc = 8'd0;
`ifdef RUN_LIMIT_EN
        run_limit = 16'd0;
`endif
        cycles(3);
        chk("reset_state", state, 2'd0);
        chk("reset_halted", halted, 1'b1);

        // Free run for 20 cycles
        rst = 1'b0; run_sw = 1'b1;
        cycles(20);
        chk("s1_state", state, 2'd1);
        chk("s1_count", step_count, 16'd4);
        chk("s1_halted", halted, 1'b0);

        // Bouncy single step from IDLE
        run_sw = 1'b0;
        cycles(8);
        c0 = m_count;
        step_key = 1'b0; cycles(2); step_key = 1'b1; cycles(2);
        step_key = 1'b0; cycles(2); step_key = 1'b1; cycles(1);
        step_key = 1'b0; cycles(10);
        step_key = 1'b1; cycles(2); step_key = 1'b0; cycles(1);
        step_key = 1'b1; cycles(10);
        chk("s2_one_step", step_count, 16'(c0 + 1));
        chk("s2_idle", state, 2'd0);

        // Breakpoint at 0x05
        rst = 1'b1; cyc(); rst = 1'b0;
        bp_en = 1'b1; bp_addr = 8'h05; run_sw = 1'b1;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin cyc(); ok = (m_mode == 3); end
        chk("s3_reach_break", ok, 1'b1);
        cycles(3);
        chk("s3_state", state, 2'd3);
        chk("s3_pc", pc, 8'h05);
        chk("s3_count", step_count, 16'd5);

        // Step out of BREAK, then keep running past the breakpoint
        step_key = 1'b0; cycles(8); step_key = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin cyc(); ok = (m_mode == 1); end
        chk("s4_back_to_run", ok, 1'b1);
        chk("s4_pc", pc, 8'h06);
        cycles(20);
        chk("s4_count", step_count, 16'd11);
        chk("s4_state", state, 2'd1);

        // Reset in the cycle a pulse is due
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc(); ok = (m_mode == 1 && (m_runcyc % TD) == TD - 1);
        end
        chk("s5_due_found", ok, 1'b1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("s5_ce", cpu_ce, 1'b0);
        chk("s5_count", step_count, 16'd0);
        run_sw = 1'b0; bp_en = 1'b0; cycles(4);

`ifdef RUN_LIMIT_EN
        // Run limit of three pulses, then rearm by toggling run_sw
        run_limit = 16'd3; run_sw = 1'b1;
        cycles(40);
        chk("s6_state", state, 2'd0);
        chk("s6_count", step_count, 16'd3);
        run_sw = 1'b0; cycles(5); run_sw = 1'b1;
        cycles(40);
        chk("s6_count2", step_count, 16'd6);
        run_sw = 1'b0; cycles(5);
`endif

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 5) == 0) step_key = ~step_key;
            if ($urandom_range(0, 99) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 29) == 0) bp_addr = pc + 8'($urandom_range(0, 3));
`ifdef RUN_LIMIT_EN
            if ($urandom_range(0, 199) == 0) run_limit = 16'($urandom_range(0, 5));
`endif
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
